// File: rtl/i2c_master_pkg.sv
// Shared I2C master definitions: FSM states, bit quarter-phases and R/W codes.
package i2c_master_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_A_ACK,
    S_WR_DATA,
    S_W_ACK,
    S_RD_DATA,
    S_R_ACK,
    S_STOP
  } state_t;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;

  function automatic int unsigned div_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/i2c_master_if.sv
// Host-side request/response bundle of the I2C master.
interface i2c_master_if;
  logic       ENB;
  logic       START;
  logic [6:0] ADDR;
  logic       RW;
  logic [7:0] D;
  logic [7:0] Q;
  logic       BUSY;
  logic       DONE;
  logic       ACK_ERR;

  modport master (
    input  ENB, START, ADDR, RW, D,
    output Q, BUSY, DONE, ACK_ERR
  );

  modport slave (
    output ENB, START, ADDR, RW, D,
    input  Q, BUSY, DONE, ACK_ERR
  );
endinterface

// File: rtl/i2c_phase_gen.sv
// SCL quarter-phase generator: CLK_DIV divider plus 2-bit phase counter.
// Cleared while idle; holds its position whenever enb is low.
module i2c_phase_gen
  import i2c_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   run,
  input  logic   enb,
  output phase_t phase,
  output logic   phase_tick,
  output logic   phase_first
);
  localparam int unsigned   DW       = div_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          adv;

  assign adv         = run && enb;
  assign phase_tick  = adv && (div_cnt == DIV_LAST);
  assign phase_first = adv && (div_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= P0;
    end else if (!run) begin
      div_cnt <= '0;
      phase   <= P0;
    end else if (adv) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        phase   <= phase_t'(phase + 2'd1);
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C bus master: START, 7-bit address + R/W, one data byte, STOP.
// SDA is open-drain (0 or z); SCL is driven and never stretched.
module i2c_master
  import i2c_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  i2c_master_if.master host,
  output logic         SCL,
  inout  wire          SDA
);
  state_t     state_q, state_d;
  phase_t     phase;
  logic       phase_tick, phase_first;
  logic       accept, bit_end, smp_now, busy;
  logic       sda_in, sda_smp, sda_bit, sda_low, scl_c, scl_bit;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, d_q, q_q;
  logic       rw_q, ack_err_q, done_q;

  assign sda_in  = SDA;
  assign busy    = (state_q != S_IDLE);
  assign accept  = host.START && host.ENB && !busy;
  assign bit_end = phase_tick && (phase == P3);
  assign smp_now = phase_first && (phase == P3);
  assign scl_bit = (phase == P2) || (phase == P3);
  // With CLK_DIV=1 the sample cycle is also the bit's last cycle, so bypass the register.
  assign sda_bit = smp_now ? sda_in : sda_smp;

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk        (CLK),
    .rst_n      (RESET),
    .run        (busy),
    .enb        (host.ENB),
    .phase      (phase),
    .phase_tick (phase_tick),
    .phase_first(phase_first)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    scl_c   = 1'b1;
    sda_low = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: begin
        sda_low = scl_bit;
        if (bit_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        scl_c   = scl_bit;
        sda_low = !shreg[7];
        if (bit_end && (bit_cnt == 3'd7)) state_d = S_A_ACK;
      end
      S_A_ACK: begin
        scl_c = scl_bit;
        if (bit_end) begin
          if (sda_bit)               state_d = S_STOP;
          else if (rw_q == I2C_RD)   state_d = S_RD_DATA;
          else                       state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        scl_c   = scl_bit;
        sda_low = !shreg[7];
        if (bit_end && (bit_cnt == 3'd7)) state_d = S_W_ACK;
      end
      S_W_ACK: begin
        scl_c = scl_bit;
        if (bit_end) state_d = S_STOP;
      end
      S_RD_DATA: begin
        scl_c = scl_bit;
        if (bit_end && (bit_cnt == 3'd7)) state_d = S_R_ACK;
      end
      S_R_ACK: begin
        scl_c = scl_bit;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        scl_c   = scl_bit;
        sda_low = (phase != P3);
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shreg     <= '0;
      d_q       <= '0;
      q_q       <= '0;
      rw_q      <= I2C_WR;
      bit_cnt   <= '0;
      sda_smp   <= 1'b1;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        shreg     <= {host.ADDR, host.RW};
        d_q       <= host.D;
        rw_q      <= host.RW;
        bit_cnt   <= '0;
        ack_err_q <= 1'b0;
      end
      if (smp_now) sda_smp <= sda_in;
      if (bit_end) begin
        unique case (state_q)
          S_ADDR, S_WR_DATA: begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_RD_DATA: begin
            shreg   <= {shreg[6:0], sda_bit};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_A_ACK: begin
            if (sda_bit) ack_err_q <= 1'b1;
            else         shreg     <= d_q;
          end
          S_W_ACK: begin
            if (sda_bit) ack_err_q <= 1'b1;
          end
          S_R_ACK: q_q    <= shreg;
          S_STOP:  done_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign SCL          = scl_c;
  assign SDA          = sda_low ? 1'b0 : 1'bz;
  assign host.Q       = q_q;
  assign host.BUSY    = busy;
  assign host.DONE    = done_q;
  assign host.ACK_ERR = ack_err_q;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: table of transactions against a
// behavioural I2C slave at 7'h42, plus freeze, ignored-START and reset sequences.
module tb_i2c_master;
  import i2c_master_pkg::*;

  localparam logic [6:0] SLV_ADDR   = 7'h42;
  localparam int         FREEZE_LEN = 50;
  localparam int         MAX_CYC    = 2000;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic scl;
  wire  sda_bus;

  i2c_master_if host();

  i2c_master #(.CLK_DIV(4)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .host (host),
    .SCL  (scl),
    .SDA  (sda_bus)
  );

  pullup (sda_bus);

  always #5 CLK = ~CLK;

  // Behavioural slave state
  logic       scl_d = 1'b1, sda_d = 1'b1;
  logic       slv_low = 1'b0;
  logic       slv_active = 1'b0;
  logic [3:0] slv_k = 4'd15;
  int         slv_byte = 0;
  logic [7:0] slv_rx = '0, slv_addr_byte = '0, slv_data_byte = '0;
  logic       slv_data_seen = 1'b0, slv_data_ack = 1'b1;
  int         slv_start_cnt = 0;
  logic [7:0] slv_tx = '0;
  logic       slv_nack = 1'b0;

  assign sda_bus = slv_low ? 1'b0 : 1'bz;

  always @(posedge CLK) begin
    logic [3:0] nk;
    int         nb;
    logic       sel;
    scl_d <= scl;
    sda_d <= sda_bus;
    sel = (slv_addr_byte[7:1] == SLV_ADDR);
    if (scl_d && scl && sda_d && !sda_bus) begin
      slv_active    <= 1'b1;
      slv_k         <= 4'd15;
      slv_byte      <= 0;
      slv_low       <= 1'b0;
      slv_addr_byte <= '0;
      slv_data_byte <= '0;
      slv_data_seen <= 1'b0;
      slv_data_ack  <= 1'b1;
      slv_start_cnt <= slv_start_cnt + 1;
    end else if (scl_d && scl && !sda_d && sda_bus) begin
      slv_active <= 1'b0;
      slv_low    <= 1'b0;
    end else if (slv_active && !scl_d && scl) begin
      if (slv_k < 4'd8) begin
        slv_rx <= {slv_rx[6:0], sda_bus};
        if (slv_k == 4'd7 && slv_byte == 0) slv_addr_byte <= {slv_rx[6:0], sda_bus};
        if (slv_k == 4'd7 && slv_byte == 1) begin
          slv_data_byte <= {slv_rx[6:0], sda_bus};
          slv_data_seen <= 1'b1;
        end
      end else if (slv_k == 4'd8 && slv_byte == 1) begin
        slv_data_ack <= sda_bus;
      end
    end else if (slv_active && scl_d && !scl) begin
      if (slv_k == 4'd15)     begin nk = 4'd0; nb = slv_byte; end
      else if (slv_k == 4'd8) begin nk = 4'd0; nb = slv_byte + 1; end
      else                    begin nk = slv_k + 4'd1; nb = slv_byte; end
      slv_k    <= nk;
      slv_byte <= nb;
      slv_low  <= 1'b0;
      if (nb == 0 && nk == 4'd8 && sel)
        slv_low <= 1'b1;
      else if (nb == 1 && sel && slv_addr_byte[0] && nk < 4'd8)
        slv_low <= !slv_tx[3'd7 - nk[2:0]];
      else if (nb == 1 && sel && !slv_addr_byte[0] && nk == 4'd8)
        slv_low <= !slv_nack;
    end
  end

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] d;
    logic [7:0] slv_tx;
    logic       slv_nack;
    int         exp_cycles;
    logic       exp_ack_err;
    logic [7:0] exp_q;
    logic [7:0] exp_addr_byte;
    logic       exp_data_seen;
    logic [7:0] exp_data_byte;
    logic       exp_data_ack;
  } vec_t;

  vec_t vecs [7];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int freeze_at, input int glitch_at,
                         output int cycles, output bit frozen_ok);
    logic hold_scl, hold_sda;
    hold_scl  = 1'b1;
    hold_sda  = 1'b1;
    frozen_ok = 1'b1;
    cycles    = 0;
    slv_tx    = v.slv_tx;
    slv_nack  = v.slv_nack;
    @(negedge CLK);
    host.ADDR  = v.addr;
    host.RW    = v.rw;
    host.D     = v.d;
    host.ENB   = 1'b1;
    host.START = 1'b1;
    for (int n = 0; n < MAX_CYC; n++) begin
      @(posedge CLK);
      cycles++;
      @(negedge CLK);
      host.START = 1'b0;
      if (host.DONE) break;
      if (cycles == glitch_at) begin
        host.START = 1'b1;
        host.ADDR  = 7'h11;
        host.RW    = I2C_RD;
        host.D     = 8'h00;
      end
      if (freeze_at > 0) begin
        if (cycles == freeze_at) begin
          host.ENB = 1'b0;
          hold_scl = scl;
          hold_sda = sda_bus;
        end else if (cycles > freeze_at && cycles <= freeze_at + FREEZE_LEN) begin
          if (scl !== hold_scl || sda_bus !== hold_sda || host.BUSY !== 1'b1) frozen_ok = 1'b0;
          if (cycles == freeze_at + FREEZE_LEN) host.ENB = 1'b1;
        end
      end
    end
  endtask

  task automatic check_txn(input string tag, input vec_t v, input int cycles, input int starts_before);
    chk({tag, " cycles"},    cycles,             v.exp_cycles);
    chk({tag, " done"},      host.DONE,          32'd1);
    chk({tag, " ack_err"},   host.ACK_ERR,       v.exp_ack_err);
    chk({tag, " q"},         host.Q,             v.exp_q);
    chk({tag, " addr_byte"}, slv_addr_byte,      v.exp_addr_byte);
    chk({tag, " data_seen"}, slv_data_seen,      v.exp_data_seen);
    if (v.exp_data_seen)
      chk({tag, " data_byte"}, slv_data_byte,    v.exp_data_byte);
    chk({tag, " data_ack"},  slv_data_ack,       v.exp_data_ack);
    chk({tag, " starts"},    slv_start_cnt,      starts_before + 1);
    @(negedge CLK);
    chk({tag, " done_pulse"}, host.DONE,         32'd0);
    chk({tag, " busy_end"},   host.BUSY,         32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   s0;
    bit   fz;
    bit   idle_ok;
    vec_t v;

    //          addr   rw      d      slv_tx nack cyc  aerr q      abyte  seen dbyte  dack
    vecs[0] = '{7'h42, I2C_WR, 8'h5A, 8'h00, 1'b0, 321, 1'b0, 8'h00, 8'h84, 1'b1, 8'h5A, 1'b0};
    vecs[1] = '{7'h42, I2C_RD, 8'h00, 8'hC3, 1'b0, 321, 1'b0, 8'hC3, 8'h85, 1'b1, 8'hC3, 1'b1};
    vecs[2] = '{7'h11, I2C_WR, 8'h77, 8'h00, 1'b0, 177, 1'b1, 8'hC3, 8'h22, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{7'h42, I2C_WR, 8'hFF, 8'h00, 1'b1, 321, 1'b1, 8'hC3, 8'h84, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{7'h11, I2C_RD, 8'h00, 8'hAA, 1'b0, 177, 1'b1, 8'hC3, 8'h23, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{7'h42, I2C_RD, 8'h00, 8'h3C, 1'b0, 321, 1'b0, 8'h3C, 8'h85, 1'b1, 8'h3C, 1'b1};
    vecs[6] = '{7'h42, I2C_WR, 8'hA5, 8'h00, 1'b0, 321, 1'b0, 8'h3C, 8'h84, 1'b1, 8'hA5, 1'b0};

    host.ENB   = 1'b1;
    host.START = 1'b0;
    host.ADDR  = '0;
    host.RW    = I2C_WR;
    host.D     = '0;
    RESET      = 1'b0;

    @(negedge CLK);
    chk("reset scl",     scl,          32'd1);
    chk("reset sda",     sda_bus,      32'd1);
    chk("reset busy",    host.BUSY,    32'd0);
    chk("reset done",    host.DONE,    32'd0);
    chk("reset ack_err", host.ACK_ERR, 32'd0);
    chk("reset q",       host.Q,       32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 7; i++) begin
      s0 = slv_start_cnt;
      run_txn(vecs[i], -1, -1, cyc, fz);
      check_txn($sformatf("vec%0d", i), vecs[i], cyc, s0);
      repeat (4) @(negedge CLK);
    end

    // ENB dropped mid WR_DATA: the transfer stretches by exactly the frozen cycles
    v = vecs[0];
    v.exp_q      = 8'h3C;
    v.exp_cycles = 321 + FREEZE_LEN;
    s0 = slv_start_cnt;
    run_txn(v, 200, -1, cyc, fz);
    chk("freeze held", fz, 32'd1);
    check_txn("freeze", v, cyc, s0);
    repeat (4) @(negedge CLK);

    // START while BUSY with different request fields must be ignored
    v = vecs[0];
    v.exp_q = 8'h3C;
    s0 = slv_start_cnt;
    run_txn(v, -1, 50, cyc, fz);
    check_txn("busy_start", v, cyc, s0);

    // START with ENB low must not launch anything
    idle_ok = 1'b1;
    s0 = slv_start_cnt;
    @(negedge CLK);
    host.ENB   = 1'b0;
    host.START = 1'b1;
    host.ADDR  = 7'h42;
    repeat (20) begin
      @(negedge CLK);
      if (host.BUSY !== 1'b0 || scl !== 1'b1 || sda_bus !== 1'b1) idle_ok = 1'b0;
    end
    host.START = 1'b0;
    host.ENB   = 1'b1;
    repeat (5) @(negedge CLK);
    chk("enb0 idle",   idle_ok,       32'd1);
    chk("enb0 busy",   host.BUSY,     32'd0);
    chk("enb0 starts", slv_start_cnt, s0);

    // Reset mid-ADDR while SCL low and SDA driven low (bit 3 of 8'h85)
    slv_tx = 8'h00;
    @(negedge CLK);
    host.ADDR  = 7'h42;
    host.RW    = I2C_RD;
    host.START = 1'b1;
    @(negedge CLK);
    host.START = 1'b0;
    repeat (66) @(negedge CLK);
    chk("midaddr scl_low", scl,       32'd0);
    chk("midaddr sda_low", sda_bus,   32'd0);
    chk("midaddr busy",    host.BUSY, 32'd1);
    RESET = 1'b0;
    #2;
    chk("midreset scl",     scl,          32'd1);
    chk("midreset sda",     sda_bus,      32'd1);
    chk("midreset busy",    host.BUSY,    32'd0);
    chk("midreset done",    host.DONE,    32'd0);
    chk("midreset ack_err", host.ACK_ERR, 32'd0);
    chk("midreset q",       host.Q,       32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
